pixel_unpack_ctrl: RTL and testbench

- Sequencer for the VGA pixel-unpack path.
- Pops packed pixel words from the upstream write FIFO and slices each word into PIX_PER_WORD pixels, most-significant pixel first.
- Presents the pixels one at a time to the frame-buffer write port through a valid/ready handshake, with a per-pixel frame-buffer address that wraps at end of frame.
- Replaces free-running unpacking with FIFO-empty and backpressure-aware control.

---
 rtl/pixel_unpack_ctrl.sv | 105 ++++++++++
 tb/tb_pixel_unpack_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpack_ctrl.sv
// Pixel-unpack sequencer: pops packed words from the write FIFO and hands the
// pixels, most-significant first, to the frame-buffer port with a wrapping address.
//
// state | meaning
// IDLE  | waiting for enable with a non-empty FIFO
// REQ   | fifo_rdreq strobe for one cycle
// LOAD  | fifo_q valid this cycle, captured into the word register
// EMIT  | presenting pixel idx until the frame buffer accepts it
module pixel_unpack_ctrl #(
  parameter int PIX_W        = 24,
  parameter int PIX_PER_WORD = 8,
  parameter int WORD_W       = PIX_W * PIX_PER_WORD,
  parameter int ADDR_W       = 13,
  parameter int FRAME_PIXELS = 8192
) (
  input  logic              wrclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              addr_clr,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic              busy
);

  localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr;
  logic              hs;
  logic              fetch_ok;
  logic [PIX_W-1:0]  slices [PIX_PER_WORD];

  assign hs       = (state == EMIT) && pix_ready;
  assign fetch_ok = enable && !fifo_empty;

  // slice 0 is the top of the word so idx 0 emits the most-significant pixel
  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_slice
    assign slices[i] = word[PIX_W*(PIX_PER_WORD-1-i) +: PIX_W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fetch_ok) state_nxt = REQ;
      REQ:  state_nxt = LOAD;
      LOAD: state_nxt = EMIT;
      EMIT: if (hs && idx == LAST_IDX) state_nxt = fetch_ok ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        word <= fifo_q;
        idx  <= '0;
      end else if (hs && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // addr_clr wins over a same-cycle increment, but the frame pulse still fires
  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs && (addr == LAST_ADDR);
      if (addr_clr)
        addr <= '0;
      else if (hs)
        addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    end
  end

  assign fifo_rdreq = (state == REQ);
  assign pix_valid  = (state == EMIT);
  assign pix_data   = slices[idx];
  assign pix_addr   = addr;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pixel_unpack_ctrl.sv
// Scoreboard bench for pixel_unpack_ctrl, built with a 16-pixel frame so the
// address wrap and frame_done pulse are reached within two words.
module tb_pixel_unpack_ctrl;

  localparam int PIX_W  = 24;
  localparam int PPW    = 8;
  localparam int WORD_W = PIX_W * PPW;
  localparam int ADDR_W = 13;
  localparam int FP     = 16;

  logic              wrclk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              addr_clr = 1'b0;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_q = '0;
  logic              fifo_rdreq;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [PIX_W-1:0]  pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              frame_done;
  logic              busy;

  pixel_unpack_ctrl #(
    .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .WORD_W(WORD_W),
    .ADDR_W(ADDR_W), .FRAME_PIXELS(FP)
  ) dut (
    .wrclk(wrclk), .rst(rst), .enable(enable), .addr_clr(addr_clr),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_addr(pix_addr), .frame_done(frame_done), .busy(busy)
  );

  always #5 wrclk = ~wrclk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // upstream FIFO model (non-show-ahead)
  logic [WORD_W-1:0] mem [64];
  int pushed = 0;
  int popped = 0;
  assign fifo_empty = (pushed == popped);

  always @(posedge wrclk) begin
    if (fifo_rdreq) begin
      fifo_q <= mem[popped % 64];
      popped <= popped + 1;
    end
  end

  logic [PIX_W-1:0] exp_q [$];

  task automatic push_word(input logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7);
    mem[pushed % 64] = {p0, p1, p2, p3, p4, p5, p6, p7};
    exp_q.push_back(p0); exp_q.push_back(p1); exp_q.push_back(p2); exp_q.push_back(p3);
    exp_q.push_back(p4); exp_q.push_back(p5); exp_q.push_back(p6); exp_q.push_back(p7);
    pushed = pushed + 1;
  endtask

  // monitor: inputs change at posedge+2, so negedge sees what the next edge will use
  int  exp_addr = 0;
  bit  exp_fd = 0;
  bit  next_fd;
  int  rdreq_cnt = 0;
  int  fd_cnt = 0;
  bit  had_valid = 0;
  int  gap = 0;
  int  gap_any = 0;
  int  gap_ok = 0;
  logic [PIX_W-1:0] exp_px;

  always @(negedge wrclk) begin
    if (rst) begin
      exp_q.delete();
      exp_addr = 0;
      exp_fd = 0;
      had_valid = 0;
      gap = 0;
    end else begin
      if (exp_fd || frame_done) chk("frame_done", 64'(frame_done), 64'(exp_fd));
      if (frame_done) fd_cnt++;
      if (fifo_rdreq) begin
        rdreq_cnt++;
        chk("rdreq_while_empty", 64'(pushed == popped), 64'd0);
      end
      next_fd = 0;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 64'(pix_data), 64'hx);
        end else begin
          exp_px = exp_q.pop_front();
          chk("pix_data", 64'(pix_data), 64'(exp_px));
          chk("pix_addr", 64'(pix_addr), 64'(exp_addr));
        end
        next_fd = (exp_addr == FP - 1);
        exp_addr = (exp_addr == FP - 1) ? 0 : exp_addr + 1;
      end
      if (addr_clr) exp_addr = 0;
      exp_fd = next_fd;
      if (!busy) begin
        had_valid = 0;
        gap = 0;
      end else if (pix_valid) begin
        if (had_valid && gap > 0) begin
          gap_any++;
          if (gap == 2) gap_ok++;
        end
        had_valid = 1;
        gap = 0;
      end else if (had_valid) begin
        gap++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_data", 64'(pix_data), 64'd0);
    chk("rst_addr", 64'(pix_addr), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge wrclk);
    @(posedge wrclk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    do begin
      @(posedge wrclk); #2;
      n++;
    end while (!(pix_valid && pix_addr == ADDR_W'(a)) && n < 100);
    if (n >= 100) chk("timeout_wait_addr", 64'(n), 64'(a));
  endtask

  task automatic wait_idle(input bit drain);
    int n = 0;
    do begin
      @(posedge wrclk); #2;
      n++;
    end while ((busy || (drain && exp_q.size() != 0)) && n < 200);
    if (n >= 200) chk("timeout_wait_idle", 64'(n), 64'd0);
  endtask

  int r0, lat, g0, gk0, f0;

  initial begin
    #3;
    do_reset();

    // single word, latency and ordering
    push_word(24'h111111, 24'h222222, 24'h333333, 24'h444444,
              24'h555555, 24'h666666, 24'h777777, 24'h888888);
    r0 = rdreq_cnt;
    enable = 1'b1; pix_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge wrclk); #1;
      lat++;
    end while (!pix_valid && lat < 10);
    chk("first_valid_latency", 64'(lat), 64'd3);
    chk("first_pixel", 64'(pix_data), 64'h111111);
    wait_idle(1);
    chk("single_rdreq", 64'(rdreq_cnt - r0), 64'd1);
    chk("single_idle_busy", 64'(busy), 64'd0);

    // backpressure at idx 3
    enable = 1'b0;
    do_reset();
    push_word(24'h111111, 24'h222222, 24'h333333, 24'h444444,
              24'h555555, 24'h666666, 24'h777777, 24'h888888);
    r0 = rdreq_cnt;
    enable = 1'b1; pix_ready = 1'b1;
    wait_addr(3);
    pix_ready = 1'b0;
    repeat (4) begin
      @(negedge wrclk);
      chk("bp_hold_data", 64'(pix_data), 64'h444444);
      chk("bp_hold_addr", 64'(pix_addr), 64'd3);
      chk("bp_hold_valid", 64'(pix_valid), 64'd1);
      @(posedge wrclk);
    end
    #2 pix_ready = 1'b1;
    @(posedge wrclk); #2;
    chk("bp_resume_data", 64'(pix_data), 64'h555555);
    chk("bp_resume_addr", 64'(pix_addr), 64'd4);
    wait_idle(1);
    chk("bp_rdreq", 64'(rdreq_cnt - r0), 64'd1);

    // back-to-back words spanning the whole 16-pixel frame
    enable = 1'b0;
    do_reset();
    push_word(24'hA00000, 24'hA11111, 24'hA22222, 24'hA33333,
              24'hA44444, 24'hA55555, 24'hA66666, 24'hA77777);
    push_word(24'hB00000, 24'hB11111, 24'hB22222, 24'hB33333,
              24'hB44444, 24'hB55555, 24'hB66666, 24'hB77777);
    r0 = rdreq_cnt; g0 = gap_any; gk0 = gap_ok; f0 = fd_cnt;
    enable = 1'b1; pix_ready = 1'b1;
    wait_idle(1);
    repeat (2) @(posedge wrclk);
    chk("b2b_rdreq", 64'(rdreq_cnt - r0), 64'd2);
    chk("b2b_gap_count", 64'(gap_any - g0), 64'd1);
    chk("b2b_gap_len2", 64'(gap_ok - gk0), 64'd1);
    chk("wrap_frame_done_pulses", 64'(fd_cnt - f0), 64'd1);
    chk("wrap_addr_zero", 64'(pix_addr), 64'd0);

    // enable / empty gating in IDLE, then enable dropped mid-word
    enable = 1'b0;
    do_reset();
    r0 = rdreq_cnt;
    enable = 1'b1;
    repeat (5) @(posedge wrclk);
    #2;
    chk("empty_busy", 64'(busy), 64'd0);
    chk("empty_rdreq", 64'(rdreq_cnt - r0), 64'd0);
    enable = 1'b0;
    push_word(24'hC00001, 24'hC00002, 24'hC00003, 24'hC00004,
              24'hC00005, 24'hC00006, 24'hC00007, 24'hC00008);
    push_word(24'hD00001, 24'hD00002, 24'hD00003, 24'hD00004,
              24'hD00005, 24'hD00006, 24'hD00007, 24'hD00008);
    repeat (5) @(posedge wrclk);
    #2;
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("disabled_rdreq", 64'(rdreq_cnt - r0), 64'd0);
    enable = 1'b1;
    wait_addr(2);
    enable = 1'b0;
    wait_idle(0);
    repeat (3) @(posedge wrclk);
    #2;
    chk("drop_word_finished", 64'(exp_q.size()), 64'd8);
    chk("drop_rdreq", 64'(rdreq_cnt - r0), 64'd1);
    chk("drop_idle_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    wait_idle(1);
    chk("drain_rdreq", 64'(rdreq_cnt - r0), 64'd2);

    // addr_clr coincident with the handshake at address 6
    enable = 1'b0;
    do_reset();
    push_word(24'hE00000, 24'hE11111, 24'hE22222, 24'hE33333,
              24'hE44444, 24'hE55555, 24'hE66666, 24'hE77777);
    enable = 1'b1; pix_ready = 1'b1;
    wait_addr(6);
    addr_clr = 1'b1;
    @(posedge wrclk); #2;
    addr_clr = 1'b0;
    chk("clr_addr", 64'(pix_addr), 64'd0);
    chk("clr_data", 64'(pix_data), 64'hE77777);
    chk("clr_valid", 64'(pix_valid), 64'd1);
    wait_idle(1);

    // reset mid-word at idx 5: outputs drop at once, FIFO not re-read
    enable = 1'b0;
    do_reset();
    push_word(24'hF00000, 24'hF11111, 24'hF22222, 24'hF33333,
              24'hF44444, 24'hF55555, 24'hF66666, 24'hF77777);
    r0 = rdreq_cnt;
    enable = 1'b1; pix_ready = 1'b1;
    wait_addr(5);
    do_reset();
    repeat (5) @(posedge wrclk);
    #2;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rdreq", 64'(rdreq_cnt - r0), 64'd1);
    chk("rst_mid_fifo_pops", 64'(popped), 64'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
